// File: rtl/int_alu_pkg.sv
// Shared integer-ALU types: lane-size and form encodings, arbiter state, adder operation payload.
package int_alu_pkg;

    localparam int unsigned DW = 32;

    localparam logic [1:0] VEC_8  = 2'd0;
    localparam logic [1:0] VEC_16 = 2'd1;
    localparam logic [1:0] VEC_32 = 2'd2;
    localparam logic [1:0] VEC_64 = 2'd3;

    localparam logic FORM_DUAL  = 1'b0;
    localparam logic FORM_CARRY = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic          form;
        logic [1:0]    vec;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] d;
    } add_op_t;

endpackage

// File: rtl/int_adder.sv
// SIMD integer add datapath: dual lane-wise add, or 3-input add with carry-out into Y1; vec=3 is a 64-bit add.
module int_adder
    import int_alu_pkg::*;
(
    input  add_op_t       op,
    output logic [DW-1:0] y1_c,
    output logic [DW-1:0] y2_c
);

    logic [9:0]  s8;
    logic [17:0] s16;
    logic [33:0] s32;
    logic [63:0] s64;

    always_comb begin
        y1_c = '0;
        y2_c = '0;
        s8   = '0;
        s16  = '0;
        s32  = '0;
        s64  = '0;
        case (op.vec)
            VEC_8: begin
                for (int i = 0; i < 4; i++) begin
                    s8 = 10'(op.a[8*i +: 8]) + 10'(op.b[8*i +: 8]) + 10'(op.c[8*i +: 8]);
                    if (op.form == FORM_CARRY) begin
                        y2_c[8*i +: 8] = s8[7:0];
                        y1_c[8*i +: 8] = 8'(s8[9:8]);
                    end else begin
                        y1_c[8*i +: 8] = op.a[8*i +: 8] + op.c[8*i +: 8];
                        y2_c[8*i +: 8] = op.b[8*i +: 8] + op.d[8*i +: 8];
                    end
                end
            end
            VEC_16: begin
                for (int i = 0; i < 2; i++) begin
                    s16 = 18'(op.a[16*i +: 16]) + 18'(op.b[16*i +: 16]) + 18'(op.c[16*i +: 16]);
                    if (op.form == FORM_CARRY) begin
                        y2_c[16*i +: 16] = s16[15:0];
                        y1_c[16*i +: 16] = 16'(s16[17:16]);
                    end else begin
                        y1_c[16*i +: 16] = op.a[16*i +: 16] + op.c[16*i +: 16];
                        y2_c[16*i +: 16] = op.b[16*i +: 16] + op.d[16*i +: 16];
                    end
                end
            end
            VEC_32: begin
                s32 = 34'(op.a) + 34'(op.b) + 34'(op.c);
                if (op.form == FORM_CARRY) begin
                    y2_c = s32[31:0];
                    y1_c = 32'(s32[33:32]);
                end else begin
                    y1_c = op.a + op.c;
                    y2_c = op.b + op.d;
                end
            end
            default: begin
                s64  = {op.a, op.b} + {op.c, op.d};
                y1_c = s64[63:32];
                y2_c = s64[31:0];
            end
        endcase
    end

endmodule

// File: rtl/rr_arbiter_core.sv
// Round-robin arbiter: search starts at the pointer and wraps; pointer moves past each winner.
module rr_arbiter_core #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt_c,
    output logic [IDW-1:0]  gnt_id_c,
    output logic            gnt_any_c
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    int unsigned    sum;

    always_comb begin
        gnt_c     = '0;
        gnt_id_c  = '0;
        gnt_any_c = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = IDW'(sum);
            if (en && !gnt_any_c && req[idx]) begin
                gnt_any_c  = 1'b1;
                gnt_c[idx] = 1'b1;
                gnt_id_c   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any_c) begin
            if (32'(gnt_id_c) == NREQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_id_c + IDW'(1);
            end
        end
    end

endmodule

// File: rtl/int_adder_arbiter.sv
// Shares one int_adder between NREQ requesters with round-robin grant and a single tagged result register.
// Optional INT_ADDER_ARBITER_PERF_EN adds perf_busy / perf_conflict cycle counters.
module int_adder_arbiter
    import int_alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_form,
    input  logic [2*NREQ-1:0]  req_vec,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [32*NREQ-1:0] req_c,
    input  logic [32*NREQ-1:0] req_d,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [31:0]        resp_y1,
    output logic [31:0]        resp_y2
`ifdef INT_ADDER_ARBITER_PERF_EN
   ,output logic [31:0]        perf_busy,
    output logic [31:0]        perf_conflict
`endif
);

    state_e         state, state_nxt;
    logic           can_issue_c;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    add_op_t        op_c;
    logic [DW-1:0]  y1_c, y2_c;

    // Reset also blocks grants so nothing is accepted while rst_n is low.
    assign can_issue_c = rst_n && ((state == ST_EMPTY) || resp_ready);
    assign req_ready   = gnt;

    rr_arbiter_core #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .en       (can_issue_c),
        .gnt_c    (gnt),
        .gnt_id_c (gnt_id),
        .gnt_any_c(gnt_any)
    );

    always_comb begin
        op_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                op_c = '{form: req_form[i], vec: req_vec[2*i +: 2],
                         a: req_a[32*i +: 32], b: req_b[32*i +: 32],
                         c: req_c[32*i +: 32], d: req_d[32*i +: 32]};
            end
        end
    end

    int_adder u_add (
        .op  (op_c),
        .y1_c(y1_c),
        .y2_c(y2_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (gnt_any) state_nxt = ST_FULL;
            ST_FULL:  if (resp_ready && !gnt_any) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_y1    <= '0;
            resp_y2    <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= (state_nxt == ST_FULL);
            if (gnt_any) begin
                resp_id <= gnt_id;
                resp_y1 <= y1_c;
                resp_y2 <= y2_c;
            end
        end
    end

`ifdef INT_ADDER_ARBITER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy     <= '0;
            perf_conflict <= '0;
        end else begin
            if (resp_valid) begin
                perf_busy <= perf_busy + 32'(1);
            end
            if (gnt_any && ($countones(req_valid) >= 2)) begin
                perf_conflict <= perf_conflict + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_int_adder_arbiter.sv
// Bench for int_adder_arbiter: per-cycle reference model check plus directed literal expectations.
module tb_int_adder_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_form;
    logic [2*NREQ-1:0]  req_vec;
    logic [32*NREQ-1:0] req_a, req_b, req_c, req_d;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_y1, resp_y2;
`ifdef INT_ADDER_ARBITER_PERF_EN
    logic [31:0]        perf_busy, perf_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_form     (req_form),
        .req_vec      (req_vec),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .req_d        (req_d),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_y1      (resp_y1),
        .resp_y2      (resp_y2)
`ifdef INT_ADDER_ARBITER_PERF_EN
       ,.perf_busy    (perf_busy),
        .perf_conflict(perf_conflict)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Lane arithmetic straight from the operation definition, returns {Y1,Y2}.
    function automatic logic [63:0] ref_op(input logic form, input logic [1:0] vec,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        longint unsigned l, mask, av, bv, cv, dv, s, y1, y2;
        logic [63:0] wide;
        if (vec == 2'd3) begin
            wide = {a, b} + {c, d};
            return wide;
        end
        l = 64'd8 << vec;
        mask = (64'd1 << l) - 64'd1;
        y1 = 0;
        y2 = 0;
        for (int k = 0; k < 32 / int'(l); k++) begin
            av = (64'(a) >> (k * l)) & mask;
            bv = (64'(b) >> (k * l)) & mask;
            cv = (64'(c) >> (k * l)) & mask;
            dv = (64'(d) >> (k * l)) & mask;
            if (form) begin
                s  = av + bv + cv;
                y2 = y2 | ((s & mask) << (k * l));
                y1 = y1 | ((s >> l) << (k * l));
            end else begin
                y1 = y1 | (((av + cv) & mask) << (k * l));
                y2 = y2 | (((bv + dv) & mask) << (k * l));
            end
        end
        return {y1[31:0], y2[31:0]};
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    bit          m_full;
    int          m_ptr, m_id;
    logic [31:0] m_y1, m_y2, m_busy, m_conf;

    // Reference model: compared mid-cycle, then advanced to what the next edge must produce.
    always @(negedge clk) begin
        int g;
        bit can;
        logic [NREQ-1:0] exp_rdy;
        if (!rst_n) begin
            m_full = 0; m_ptr = 0; m_id = 0; m_y1 = '0; m_y2 = '0; m_busy = '0; m_conf = '0;
        end
        can = rst_n && (!m_full || resp_ready);
        g = can ? ref_grant(req_valid, m_ptr) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("m_resp_valid", 64'(resp_valid), 64'(m_full));
        if (m_full || !rst_n) begin
            chk("m_resp_id", 64'(resp_id), 64'(m_id));
            chk("m_resp_y1", 64'(resp_y1), 64'(m_y1));
            chk("m_resp_y2", 64'(resp_y2), 64'(m_y2));
        end
`ifdef INT_ADDER_ARBITER_PERF_EN
        chk("m_perf_busy", 64'(perf_busy), 64'(m_busy));
        chk("m_perf_conflict", 64'(perf_conflict), 64'(m_conf));
`endif
        if (rst_n) begin
            if (m_full) m_busy = m_busy + 32'd1;
            if (g >= 0) begin
                if ($countones(req_valid) >= 2) m_conf = m_conf + 32'd1;
                m_full = 1;
                m_id   = g;
                {m_y1, m_y2} = ref_op(req_form[g], req_vec[2*g +: 2], req_a[32*g +: 32],
                                      req_b[32*g +: 32], req_c[32*g +: 32], req_d[32*g +: 32]);
                m_ptr = (g + 1) % NREQ;
            end else if (m_full && resp_ready) begin
                m_full = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic f, input logic [1:0] vec,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        req_valid[i]       = v;
        req_form[i]        = f;
        req_vec[2*i +: 2]  = vec;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_c[32*i +: 32]  = c;
        req_d[32*i +: 32]  = d;
    endtask

    initial begin
        rst_n = 1'b0; resp_ready = 1'b1;
        req_valid = '0; req_form = '0; req_vec = '0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;

        // Pin the reference model against hand-derived values.
        chk("model_8b_dual", ref_op(1'b0, 2'd0, 32'h01FF0203, 32'h0, 32'h01010101, 32'h0),
            {32'h02000304, 32'h0});
        chk("model_32b_carry", ref_op(1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0),
            {32'h00000002, 32'hFFFFFFFD});
        chk("model_64b", ref_op(1'b1, 2'd3, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1),
            {32'h00000001, 32'h0});

        // Reset state, with a request pending that must not be accepted.
        req_valid[0] = 1'b1;
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_y1", 64'(resp_y1), 64'h0);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        // Single 8-bit dual add from requester 0.
        set_req(0, 1'b1, 1'b0, 2'd0, 32'h01FF0203, 32'h0, 32'h01010101, 32'h0);
        #1 chk("t2_req_ready", 64'(req_ready), 64'h1);
        step();
        chk("t2_resp_valid", 64'(resp_valid), 64'h1);
        chk("t2_resp_y1", 64'(resp_y1), 64'h02000304);
        chk("t2_resp_id", 64'(resp_id), 64'h0);
        req_valid = '0;
        step();
        chk("t2_drain", 64'(resp_valid), 64'h0);

        // Reset while a result is held; pointer must return to 0.
        req_valid[0] = 1'b1;
        step();
        chk("t1_held", 64'(resp_valid), 64'h1);
        rst_n = 1'b0;
        #1 chk("t1_async_clear", 64'(resp_valid), 64'h0);
        step();
        rst_n = 1'b1;
        set_req(1, 1'b1, 1'b0, 2'd1, 32'h0001FFFF, 32'h12345678, 32'h00010001, 32'h11111111);
        #1 chk("t1_ptr_zero", 64'(req_ready), 64'h1);

        // Both requesters continuously valid: grants alternate.
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t3_resp_valid", 64'(resp_valid), 64'h1);
            chk("t3_resp_id", 64'(resp_id), 64'(n % 2));
        end

        // Backpressure with requester 1's result held.
        resp_ready = 1'b0;
        #1 chk("t4_no_ready", 64'(req_ready), 64'h0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_hold_valid", 64'(resp_valid), 64'h1);
            chk("t4_hold_id", 64'(resp_id), 64'h1);
            chk("t4_hold_y1", 64'(resp_y1), 64'h00020000);
            chk("t4_hold_y2", 64'(resp_y2), 64'h23456789);
            chk("t4_hold_ready", 64'(req_ready), 64'h0);
        end
        resp_ready = 1'b1;
        #1 chk("t4_release_grant", 64'(req_ready), 64'h1);
        step();
        chk("t4_release_id", 64'(resp_id), 64'h0);
        req_valid = '0;
        step();

        // 32-bit three-input add with carry.
        set_req(1, 1'b1, 1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        step();
        chk("t5_y2", 64'(resp_y2), 64'hFFFFFFFD);
        chk("t5_y1", 64'(resp_y1), 64'h00000002);
        chk("t5_id", 64'(resp_id), 64'h1);
        req_valid = '0;
        step();

        // 64-bit add, form ignored.
        set_req(0, 1'b1, 1'b1, 2'd3, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1);
        step();
        chk("t6_y1", 64'(resp_y1), 64'h00000001);
        chk("t6_y2", 64'(resp_y2), 64'h0);
        req_valid = '0;
        step();

        // Mixed traffic with varying backpressure, checked by the model.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!(req_valid[i] && !req_ready[i])) begin
                    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
                end
            end
            resp_ready = (n % 5) != 3;
            step();
        end
        req_valid = '0;
        resp_ready = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
